// File: rtl/pcie_phy_pkg.sv
// Shared types and symbol constants for the PCIe PHY ordered-set transmit path.
package pcie_phy_pkg;

    typedef enum logic [1:0] {
        OsTs1  = 2'd0,
        OsTs2  = 2'd1,
        OsIdle = 2'd2,
        OsEios = 2'd3
    } os_type_e;

    localparam logic [7:0] COM_ = 8'hBC;
    localparam logic [7:0] PAD_ = 8'hF7;
    localparam logic [7:0] IDL_ = 8'h7C;

    localparam int unsigned TS_BEATS   = 4;
    localparam int unsigned EIOS_BEATS = 1;
    localparam int unsigned IDLE_BEATS = 1;
    localparam int unsigned BEAT_W     = $clog2(TS_BEATS);

endpackage

// File: rtl/os_lane_builder.sv
// Combinational per-lane ordered-set image and K-mask builder.
module os_lane_builder
    import pcie_phy_pkg::*;
#(
    parameter int unsigned MAX_NUM_LANES = 4,
    parameter int unsigned OS_SYMBOLS    = 16,
    localparam int unsigned LANE_W       = $clog2(MAX_NUM_LANES + 1)
) (
    input  logic [LANE_W-1:0]       lane_idx_i,
    input  logic [LANE_W-1:0]       active_lanes_i,
    input  logic                    lane_reverse_i,
    input  logic                    set_lane_i,
    input  os_type_e                os_type_i,
    input  logic [OS_SYMBOLS*8-1:0] os_symbols_i,
    output logic [OS_SYMBOLS*8-1:0] image_o,
    output logic [OS_SYMBOLS-1:0]   kmask_o,
    output logic                    lane_active_o
);

    logic [OS_SYMBOLS*8-1:0] img;
    logic [OS_SYMBOLS-1:0]   kmask;
    logic [LANE_W-1:0]       num;
    logic [7:0]              lane_num;

    always_comb begin
        img           = '0;
        kmask         = '0;
        lane_active_o = (lane_idx_i < active_lanes_i);
        num           = lane_reverse_i ? LANE_W'(active_lanes_i - lane_idx_i - LANE_W'(1))
                                       : lane_idx_i;
        lane_num      = 8'(num);
        if (lane_active_o) begin
            unique case (os_type_i)
                OsTs1, OsTs2: begin
                    img        = os_symbols_i;
                    img[7:0]   = COM_;
                    img[23:16] = set_lane_i ? lane_num : PAD_;
                    kmask[0]   = 1'b1;
                    kmask[1]   = (img[15:8] == PAD_);
                    kmask[2]   = (img[23:16] == PAD_);
                end
                OsEios: begin
                    img[31:0]  = {IDL_, IDL_, IDL_, COM_};
                    kmask[3:0] = 4'hF;
                end
                default: ;  // logical IDLE: all data and K-flags zero
            endcase
        end
        image_o = img;
        kmask_o = kmask;
    end

endmodule

// File: rtl/os_burst_generator.sv
// Multi-lane AXI-Stream burst generator for PCIe ordered sets (TS1/TS2/IDLE/EIOS).
module os_burst_generator
    import pcie_phy_pkg::*;
#(
    parameter int unsigned MAX_NUM_LANES = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH    = 4,
    parameter int unsigned OS_SYMBOLS    = 16,
    parameter int unsigned REPEAT_WIDTH  = 8,
    localparam int unsigned LANE_W       = $clog2(MAX_NUM_LANES + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                os_valid_i,
    output logic                                os_ready_o,
    input  logic [1:0]                          os_type_i,
    input  logic [OS_SYMBOLS*8-1:0]             os_symbols_i,
    input  logic [REPEAT_WIDTH-1:0]             repeat_cnt_i,
    input  logic [LANE_W-1:0]                   active_lanes_i,
    input  logic                                set_lane_i,
    input  logic                                lane_reverse_i,
    input  logic                                abort_i,
    output logic                                busy_o,
    output logic                                os_sent_o,
    output logic                                burst_done_o,
    output logic [DATA_WIDTH*MAX_NUM_LANES-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH*MAX_NUM_LANES-1:0] m_axis_tkeep,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    output logic [USER_WIDTH*MAX_NUM_LANES-1:0] m_axis_tuser,
    input  logic                                m_axis_tready
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e                                         state_q, state_d;
    os_type_e                                       type_q, type_d;
    logic [OS_SYMBOLS*8-1:0]                        sym_q, sym_d;
    logic [REPEAT_WIDTH-1:0]                        rem_q, rem_d;
    logic [LANE_W-1:0]                              act_q, act_d;
    logic                                           set_lane_q, set_lane_d;
    logic                                           reverse_q, reverse_d;
    logic                                           abort_q, abort_d;
    logic [BEAT_W-1:0]                              beat_q, beat_d;
    logic [MAX_NUM_LANES-1:0][OS_SYMBOLS*8-1:0]     img_q, img_d, img_w;
    logic [MAX_NUM_LANES-1:0][OS_SYMBOLS-1:0]       k_q, k_d, k_w;
    logic [MAX_NUM_LANES-1:0]                       lane_en_q, lane_en_d, lane_en_w;
    logic                                           tvalid_q, tvalid_d;
    logic                                           tlast_q, tlast_d;
    logic [DATA_WIDTH*MAX_NUM_LANES-1:0]            tdata_q, tdata_d;
    logic [KEEP_WIDTH*MAX_NUM_LANES-1:0]            tkeep_q, tkeep_d;
    logic [USER_WIDTH*MAX_NUM_LANES-1:0]            tuser_q, tuser_d;
    logic                                           os_sent_q, os_sent_d;
    logic                                           burst_done_q, burst_done_d;
    logic                                           advance;
    logic                                           abort_seen;
    logic [BEAT_W-1:0]                              last_beat;

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : gen_lane
        os_lane_builder #(
            .MAX_NUM_LANES(MAX_NUM_LANES),
            .OS_SYMBOLS   (OS_SYMBOLS)
        ) u_lane (
            .lane_idx_i    (LANE_W'(g)),
            .active_lanes_i(act_q),
            .lane_reverse_i(reverse_q),
            .set_lane_i    (set_lane_q),
            .os_type_i     (type_q),
            .os_symbols_i  (sym_q),
            .image_o       (img_w[g]),
            .kmask_o       (k_w[g]),
            .lane_active_o (lane_en_w[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        sym_d        = sym_q;
        rem_d        = rem_q;
        act_d        = act_q;
        set_lane_d   = set_lane_q;
        reverse_d    = reverse_q;
        abort_d      = abort_q;
        beat_d       = beat_q;
        img_d        = img_q;
        k_d          = k_q;
        lane_en_d    = lane_en_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tuser_d      = tuser_q;
        os_sent_d    = tvalid_q && m_axis_tready && tlast_q;
        burst_done_d = 1'b0;
        advance      = !tvalid_q || m_axis_tready;
        abort_seen   = abort_q || abort_i;
        unique case (type_q)
            OsTs1, OsTs2: last_beat = BEAT_W'(TS_BEATS - 1);
            OsEios:       last_beat = BEAT_W'(EIOS_BEATS - 1);
            default:      last_beat = BEAT_W'(IDLE_BEATS - 1);
        endcase

        unique case (state_q)
            StIdle: begin
                if (os_valid_i) begin
                    type_d     = os_type_e'(os_type_i);
                    sym_d      = os_symbols_i;
                    rem_d      = (repeat_cnt_i == '0) ? REPEAT_WIDTH'(1) : repeat_cnt_i;
                    if (active_lanes_i == '0) begin
                        act_d = LANE_W'(1);
                    end else if (active_lanes_i > LANE_W'(MAX_NUM_LANES)) begin
                        act_d = LANE_W'(MAX_NUM_LANES);
                    end else begin
                        act_d = active_lanes_i;
                    end
                    set_lane_d = set_lane_i;
                    reverse_d  = lane_reverse_i;
                    abort_d    = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                img_d     = img_w;
                k_d       = k_w;
                lane_en_d = lane_en_w;
                abort_d   = abort_seen;
                beat_d    = '0;
                state_d   = StSend;
            end
            StSend: begin
                abort_d = abort_seen;
                if (advance) begin
                    // Burst only ends once the final beat of an OS leaves the output register.
                    if (tvalid_q && tlast_q && (rem_q == REPEAT_WIDTH'(1) || abort_seen)) begin
                        tvalid_d     = 1'b0;
                        tlast_d      = 1'b0;
                        tdata_d      = '0;
                        tkeep_d      = '0;
                        tuser_d      = '0;
                        abort_d      = 1'b0;
                        burst_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        if (tvalid_q && tlast_q) begin
                            rem_d = rem_q - REPEAT_WIDTH'(1);
                        end
                        tvalid_d = 1'b1;
                        tlast_d  = (beat_q == last_beat);
                        beat_d   = (beat_q == last_beat) ? '0 : beat_q + BEAT_W'(1);
                        for (int unsigned i = 0; i < MAX_NUM_LANES; i++) begin
                            tdata_d[DATA_WIDTH*i +: DATA_WIDTH] =
                                img_q[i][DATA_WIDTH*int'(beat_q) +: DATA_WIDTH];
                            tuser_d[USER_WIDTH*i +: USER_WIDTH] =
                                k_q[i][USER_WIDTH*int'(beat_q) +: USER_WIDTH];
                            tkeep_d[KEEP_WIDTH*i +: KEEP_WIDTH] = {KEEP_WIDTH{lane_en_q[i]}};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            type_q       <= OsTs1;
            sym_q        <= '0;
            rem_q        <= '0;
            act_q        <= '0;
            set_lane_q   <= 1'b0;
            reverse_q    <= 1'b0;
            abort_q      <= 1'b0;
            beat_q       <= '0;
            img_q        <= '0;
            k_q          <= '0;
            lane_en_q    <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tuser_q      <= '0;
            os_sent_q    <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            sym_q        <= sym_d;
            rem_q        <= rem_d;
            act_q        <= act_d;
            set_lane_q   <= set_lane_d;
            reverse_q    <= reverse_d;
            abort_q      <= abort_d;
            beat_q       <= beat_d;
            img_q        <= img_d;
            k_q          <= k_d;
            lane_en_q    <= lane_en_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tuser_q      <= tuser_d;
            os_sent_q    <= os_sent_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign os_ready_o    = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign os_sent_o     = os_sent_q;
    assign burst_done_o  = burst_done_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_os_burst_generator.sv
// Scoreboard bench for os_burst_generator: model-predicted beats are queued and popped on handshake.
module tb_os_burst_generator;

    localparam int NL = 4;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         os_valid_i = 1'b0;
    logic         os_ready_o;
    logic [1:0]   os_type_i = 2'd0;
    logic [127:0] os_symbols_i = '0;
    logic [7:0]   repeat_cnt_i = '0;
    logic [2:0]   active_lanes_i = '0;
    logic         set_lane_i = 1'b0;
    logic         lane_reverse_i = 1'b0;
    logic         abort_i = 1'b0;
    logic         busy_o, os_sent_o, burst_done_o;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tvalid, m_axis_tlast;
    logic [15:0]  m_axis_tuser;
    logic         m_axis_tready = 1'b1;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic [15:0]  user;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        mon_e;
    int           errors = 0;
    int           checks = 0;
    int           beats_seen = 0;
    int           sent_seen = 0;
    int           done_seen = 0;
    int           tr_mode = 0;
    logic [127:0] first_data;
    logic [15:0]  first_keep, first_user;
    logic         prev_valid = 1'b0, prev_ready, prev_last;
    logic [127:0] prev_data;
    logic [15:0]  prev_keep, prev_user;

    os_burst_generator dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .os_valid_i    (os_valid_i),
        .os_ready_o    (os_ready_o),
        .os_type_i     (os_type_i),
        .os_symbols_i  (os_symbols_i),
        .repeat_cnt_i  (repeat_cnt_i),
        .active_lanes_i(active_lanes_i),
        .set_lane_i    (set_lane_i),
        .lane_reverse_i(lane_reverse_i),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .os_sent_o     (os_sent_o),
        .burst_done_o  (burst_done_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {K, symbol} for symbol k of lane 'lane' of one OS.
    function automatic logic [8:0] sym_of(input logic [1:0] typ, input logic [127:0] syms,
                                          input int k, input int lane, input int act,
                                          input bit sl, input bit rv);
        logic [7:0] v;
        case (typ)
            2'd0, 2'd1: begin
                if (k == 0) return {1'b1, 8'hBC};
                if (k == 2) begin
                    v = sl ? 8'(rv ? act - 1 - lane : lane) : 8'hF7;
                    return {v == 8'hF7, v};
                end
                v = syms[8*k +: 8];
                return {(k == 1) && (v == 8'hF7), v};
            end
            2'd3:    return (k == 0) ? {1'b1, 8'hBC} : {1'b1, 8'h7C};
            default: return 9'h0;
        endcase
    endfunction

    task automatic push_burst(input logic [1:0] typ, input logic [127:0] syms, input int n_os,
                              input int act, input bit sl, input bit rv);
        int nb = (typ < 2) ? 4 : 1;
        for (int os = 0; os < n_os; os++) begin
            for (int b = 0; b < nb; b++) begin
                beat_t e;
                e = '0;
                for (int l = 0; l < NL; l++) begin
                    if (l < act) begin
                        e.keep[4*l +: 4] = 4'hF;
                        for (int j = 0; j < 4; j++) begin
                            logic [8:0] s;
                            s = sym_of(typ, syms, 4*b + j, l, act, sl, rv);
                            e.data[32*l + 8*j +: 8] = s[7:0];
                            e.user[4*l + j] = s[8];
                        end
                    end
                end
                e.last = (b == nb - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [127:0] mk_ts(input logic [7:0] link, input logic [7:0] s3);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'h40 + 8'(k);
        r[7:0]   = 8'hBC;
        r[15:8]  = link;
        r[23:16] = 8'h00;
        r[31:24] = s3;
        return r;
    endfunction

    // Inputs are scrambled right after accept to confirm they are only sampled then.
    task automatic send_req(input logic [1:0] typ, input logic [127:0] syms, input int rep,
                            input int act, input bit sl, input bit rv);
        @(posedge clk);
        #1;
        check_val("ready_before_req", os_ready_o, 1);
        os_type_i      = typ;
        os_symbols_i   = syms;
        repeat_cnt_i   = 8'(rep);
        active_lanes_i = 3'(act);
        set_lane_i     = sl;
        lane_reverse_i = rv;
        os_valid_i     = 1'b1;
        @(posedge clk);
        #1;
        os_valid_i     = 1'b0;
        os_type_i      = ~typ;
        os_symbols_i   = ~syms;
        repeat_cnt_i   = 8'd1;
        active_lanes_i = 3'd1;
        set_lane_i     = ~sl;
        lane_reverse_i = ~rv;
    endtask

    task automatic run_burst(input logic [1:0] typ, input logic [127:0] syms, input int rep,
                             input int act, input bit sl, input bit rv,
                             input int abort_mode, input int trm);
        int act_eff = (act == 0) ? 1 : ((act > NL) ? NL : act);
        int n_os    = (abort_mode != 0) ? 1 : ((rep == 0) ? 1 : rep);
        int nb      = (typ < 2) ? 4 : 1;
        tr_mode    = trm;
        beats_seen = 0;
        sent_seen  = 0;
        done_seen  = 0;
        push_burst(typ, syms, n_os, act_eff, sl, rv);
        send_req(typ, syms, rep, act, sl, rv);
        if (abort_mode == 2) abort_i = 1'b1;
        @(negedge clk);
        check_val("load_tvalid", m_axis_tvalid, 0);
        check_val("load_busy", busy_o, 1);
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        @(negedge clk);
        check_val("send_tvalid", m_axis_tvalid, 0);
        @(negedge clk);
        if (trm == 0) check_val("first_tvalid", m_axis_tvalid, 1);
        if (abort_mode == 1) begin
            @(posedge clk);
            #1;
            abort_i = 1'b1;
            @(posedge clk);
            #1;
            abort_i = 1'b0;
        end
        for (int c = 0; c < 400 && done_seen == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        tr_mode = 0;
        check_val("beat_count", beats_seen, n_os * nb);
        check_val("os_sent_count", sent_seen, n_os);
        check_val("burst_done_count", done_seen, 1);
        check_val("queue_drained", exp_q.size(), 0);
        check_val("idle_busy", busy_o, 0);
        check_val("idle_ready", os_ready_o, 1);
        exp_q.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = (tr_mode == 0) ? 1'b1 : ~m_axis_tready;
        end
    end

    always @(negedge clk) begin
        if (rst_i) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check_val("stall_data", m_axis_tdata, prev_data);
                check_val("stall_ctl", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser},
                          {1'b1, prev_last, prev_keep, prev_user});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (beats_seen == 0) begin
                    first_data = m_axis_tdata;
                    first_keep = m_axis_tkeep;
                    first_user = m_axis_tuser;
                end
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", m_axis_tvalid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("tdata", m_axis_tdata, mon_e.data);
                    check_val("tkeep", m_axis_tkeep, mon_e.keep);
                    check_val("tuser", m_axis_tuser, mon_e.user);
                    check_val("tlast", m_axis_tlast, mon_e.last);
                end
            end
            if (os_sent_o) sent_seen++;
            if (burst_done_o) begin
                done_seen++;
                check_val("done_with_sent", os_sent_o, 1);
            end
            prev_valid = m_axis_tvalid;
            prev_ready = m_axis_tready;
            prev_last  = m_axis_tlast;
            prev_data  = m_axis_tdata;
            prev_keep  = m_axis_tkeep;
            prev_user  = m_axis_tuser;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] filler;
        filler = {4{32'hDEADBEEF}};
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", os_ready_o, 1);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_tvalid", m_axis_tvalid, 0);
        check_val("rst_pulses", {os_sent_o, burst_done_o}, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", os_ready_o, 1);

        // TS1 x3, four lanes numbered in order
        run_burst(2'd0, mk_ts(8'h05, 8'h4A), 3, 4, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < NL; i++) check_val("ts1_lane_num", first_data[32*i+16 +: 8], i);
        check_val("ts1_user_beat0", first_user, 16'h1111);

        // TS2 with PAD link and lane numbers
        run_burst(2'd1, mk_ts(8'hF7, 8'h4A), 1, 4, 1'b0, 1'b0, 0, 0);
        check_val("ts2_pad_data", first_data[31:0], 32'h4AF7F7BC);
        check_val("ts2_pad_user", first_user, 16'h7777);

        // Two lanes, reversed numbering
        run_burst(2'd0, mk_ts(8'h01, 8'h4A), 2, 2, 1'b1, 1'b1, 0, 0);
        check_val("rev_lane0", first_data[23:16], 8'h01);
        check_val("rev_lane1", first_data[55:48], 8'h00);
        check_val("rev_upper_zero", first_data[127:64], 0);
        check_val("rev_keep", first_keep, 16'h00FF);

        // EIOS x2 with tready toggling
        run_burst(2'd3, filler, 2, 4, 1'b1, 1'b0, 0, 1);
        check_val("eios_data", first_data[31:0], 32'h7C7C7CBC);
        check_val("eios_user", first_user, 16'hFFFF);

        // Abort during beat 2 of the first OS, and abort during load
        run_burst(2'd0, mk_ts(8'h02, 8'h4A), 10, 4, 1'b1, 1'b0, 1, 0);
        run_burst(2'd1, mk_ts(8'h03, 8'h4A), 5, 3, 1'b1, 1'b0, 2, 0);

        // Oversized lane count clamps to all lanes
        run_burst(2'd0, mk_ts(8'h07, 8'h4A), 1, 7, 1'b1, 1'b0, 0, 0);
        check_val("clamp_keep", first_keep, 16'hFFFF);

        // IDLE, repeat 0 and zero lanes clamp to one OS on lane 0
        run_burst(2'd2, filler, 0, 0, 1'b1, 1'b0, 0, 0);
        check_val("idle_keep", first_keep, 16'h000F);
        check_val("idle_data", first_data, 0);
        check_val("idle_user", first_user, 0);

        // Reset in the middle of a burst
        beats_seen = 0;
        sent_seen  = 0;
        done_seen  = 0;
        push_burst(2'd0, mk_ts(8'h05, 8'h4A), 5, 4, 1'b1, 1'b0);
        send_req(2'd0, mk_ts(8'h05, 8'h4A), 5, 4, 1'b1, 1'b0);
        for (int c = 0; c < 20 && !m_axis_tvalid; c++) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        check_val("midrst_tvalid", m_axis_tvalid, 0);
        check_val("midrst_ready", os_ready_o, 1);
        check_val("midrst_busy", busy_o, 0);
        check_val("midrst_tdata", m_axis_tdata, 0);
        check_val("midrst_pulses", {os_sent_o, burst_done_o}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (6) @(negedge clk);
        check_val("midrst_no_sent", sent_seen, 0);
        check_val("midrst_no_done", done_seen, 0);
        check_val("midrst_tvalid_after", m_axis_tvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
